// File: rtl/w_window_serializer.sv
`default_nettype none
// ============================================================================
// Module      : w_window_serializer
// Description : Upstream feeder for the 3-cycle w-window detector FSM.
//               Buffers whole window words in a small FIFO. On start it
//               pulses s for one cycle, then streams w one bit per cycle,
//               MSB first. When the FIFO is empty at a window boundary it
//               emits an all-zero filler window and flags the underrun, so
//               window alignment is never lost.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               in_valid/in_ready  - word handshake (accept on both high)
//               in_data[WIN-1:0]   - window word, bit WIN-1 sent first
//               start              - arm request, level-sampled in IDLE
//               s, w               - arm pulse and serial bit to detector
//               busy               - high in ARM and STREAM
//               level              - words stored, 0..DEPTH
//               underrun           - sticky, set on first filler window
//               underrun_cnt[7:0]  - filler windows emitted, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module w_window_serializer #(
  parameter int WIN   = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIN-1:0]           in_data,
  input  logic                     start,
  output logic                     s,
  output logic                     w,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic [7:0]               underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [WIN-1:0]  mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic [WIN-1:0]  shreg;

  logic            push;
  logic            pop;
  logic            win_start;
  logic            fifo_empty;
  logic [LW-1:0]   level_next;

  // --------------------------------------------------------------------------
  // Next-state and FIFO control. Pop decisions look only at the registered
  // level, so a word pushed this cycle is not visible until the next edge.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    push       = in_valid & in_ready;
    fifo_empty = (level == '0);
    win_start  = (state == ARM) || ((state == STREAM) && (cnt == CW'(WIN - 1)));
    pop        = win_start & ~fifo_empty;
    level_next = level;

    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end

    case (state)
      IDLE: begin
        if (start && !fifo_empty) begin
          state_next = ARM;
        end
      end
      ARM:     state_next = STREAM;
      // The detector never returns to idle, so streaming continues until reset.
      STREAM:  state_next = STREAM;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, FIFO bookkeeping and registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      in_ready     <= 1'b1;
      cnt          <= '0;
      shreg        <= '0;
      s            <= 1'b0;
      w            <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      level    <= level_next;
      in_ready <= (level_next != LW'(DEPTH));
      s        <= (state_next == ARM);
      busy     <= (state_next != IDLE);

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (win_start) begin
        // Window boundary: load the head word, or emit a filler window.
        cnt <= '0;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          w      <= mem[rd_ptr][WIN-1];
          shreg  <= mem[rd_ptr] << 1;
        end else begin
          w        <= 1'b0;
          shreg    <= '0;
          underrun <= 1'b1;
          if (underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
      end else if (state == STREAM) begin
        cnt   <= cnt + 1'b1;
        w     <= shreg[WIN-1];
        shreg <= shreg << 1;
      end else begin
        w <= 1'b0;
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_w_window_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_w_window_serializer
// Description : Self-checking bench for w_window_serializer. A reference
//               model keeps a word queue and a pending-bit queue; each edge
//               it queues the expected outputs and a monitor compares them
//               against the design half a cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w_window_serializer;

  localparam int WIN   = 3;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [WIN-1:0]  in_data;
  logic            start;
  logic            s;
  logic            w;
  logic            busy;
  logic [LW-1:0]   level;
  logic            underrun;
  logic [7:0]      underrun_cnt;

  always #5 clk = ~clk;

  w_window_serializer #(.WIN(WIN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .start        (start),
    .s            (s),
    .w            (w),
    .busy         (busy),
    .level        (level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  typedef struct {
    int s;
    int w;
    int busy;
    int level;
    int in_ready;
    int underrun;
    int ucnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // --------------------------------------------------------------------------
  // Reference model: 0 = idle, 1 = arming, 2 = streaming. Window contents are
  // expanded into a queue of pending bits; an empty bit queue while streaming
  // means a new window begins at this edge.
  // --------------------------------------------------------------------------
  initial begin : model
    int             mode;
    bit [WIN-1:0]   ref_fifo[$];
    bit             bitq[$];
    int             m_under;
    int             m_ucnt;
    int             pre;
    bit             refill;
    bit             wbit;
    bit [WIN-1:0]   word;
    exp_t           e;
    mode    = 0;
    m_under = 0;
    m_ucnt  = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mode = 0;
        ref_fifo.delete();
        bitq.delete();
        m_under = 0;
        m_ucnt  = 0;
        wbit    = 1'b0;
      end else begin
        pre    = ref_fifo.size();
        refill = 1'b0;
        wbit   = 1'b0;
        if (mode == 1) begin
          mode   = 2;
          refill = 1'b1;
        end else if (mode == 2 && bitq.size() == 0) begin
          refill = 1'b1;
        end
        if (refill) begin
          if (pre > 0) begin
            word = ref_fifo.pop_front();
            for (int k = WIN - 1; k >= 0; k--) bitq.push_back(word[k]);
          end else begin
            for (int k = 0; k < WIN; k++) bitq.push_back(1'b0);
            m_under = 1;
            if (m_ucnt < 255) m_ucnt++;
          end
        end
        if (mode == 2) wbit = bitq.pop_front();
        if (in_valid && pre < DEPTH) ref_fifo.push_back(in_data);
        if (mode == 0 && start && pre >= 1) mode = 1;
      end
      e.s        = (mode == 1) ? 1 : 0;
      e.w        = wbit ? 1 : 0;
      e.busy     = (mode != 0) ? 1 : 0;
      e.level    = ref_fifo.size();
      e.in_ready = (ref_fifo.size() < DEPTH) ? 1 : 0;
      e.underrun = m_under;
      e.ucnt     = m_ucnt;
      sbq.push_back(e);
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("s",            int'(s),            e.s);
        chk("w",            int'(w),            e.w);
        chk("busy",         int'(busy),         e.busy);
        chk("level",        int'(level),        e.level);
        chk("in_ready",     int'(in_ready),     e.in_ready);
        chk("underrun",     int'(underrun),     e.underrun);
        chk("underrun_cnt", int'(underrun_cnt), e.ucnt);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [WIN-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin : stim
    int p;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    start    = 1'b0;
    run(2);
    reset = 1'b0;

    // Single window.
    push_word(3'b110);
    pulse_start();
    run(6);

    // Back-to-back windows.
    do_reset();
    push_word(3'b101);
    push_word(3'b011);
    pulse_start();
    run(8);

    // FIFO full with a held fifth word, released by the first pop.
    do_reset();
    push_word(3'b100);
    push_word(3'b010);
    push_word(3'b001);
    push_word(3'b111);
    in_valid = 1'b1;
    in_data  = 3'b101;
    run(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    run(2);
    in_valid = 1'b0;
    run(12);

    // Underrun, then a word pushed during the filler window.
    do_reset();
    push_word(3'b111);
    pulse_start();
    run(4);
    push_word(3'b010);
    run(8);

    // Ignored start with an empty FIFO; a lone push must not arm.
    do_reset();
    start = 1'b1;
    run(5);
    start = 1'b0;
    push_word(3'b011);
    run(4);

    // Reset on the second bit of a window with two words still queued.
    do_reset();
    push_word(3'b101);
    push_word(3'b110);
    push_word(3'b011);
    pulse_start();
    run(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(3);

    // Long underrun to drive the filler counter into saturation.
    do_reset();
    push_word(3'b001);
    pulse_start();
    run(800);

    // Randomized episodes with varying push density.
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      p = $urandom_range(10, 95);
      for (int c = 0; c < 60; c++) begin
        in_valid = ($urandom_range(0, 99) < p);
        in_data  = WIN'($urandom);
        start    = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 199) == 0) reset = 1'b1;
        else reset = 1'b0;
        tick();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      reset    = 1'b0;
    end

    run(2);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
